// File: rtl/ram_partition_gate_ctrl.sv
// ram_partition_gate_ctrl: sequences resize requests for a partitioned RAM by draining
// and gating partitions on a downsize, and by ungating and settling them on an upsize.
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   reconfigReq_i       resize request, taken only while idle
//   reqParts_i          requested active partition count (1..NUM_PARTS)
//   partDrained_i       per-partition "no live entries" flags
//   ramReady_i          RAM ready after ungating
//   partitionGated_o    per-partition gate enables
//   activeParts_o       current active partition count
//   wrBlockMask_o       partitions being removed; writes must avoid them
//   busy_o              high whenever a request is in flight
//   reconfigAck_o       one-cycle completion pulse
//   reconfigErr_o       qualifies the ack: request was out of range
module ram_partition_gate_ctrl #(
    parameter int NUM_PARTS     = 8,
    parameter int NUM_PARTS_LOG = 3,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     reconfigReq_i,
    input  logic [NUM_PARTS_LOG:0]   reqParts_i,
    input  logic [NUM_PARTS-1:0]     partDrained_i,
    input  logic                     ramReady_i,
    output logic [NUM_PARTS-1:0]     partitionGated_o,
    output logic [NUM_PARTS_LOG:0]   activeParts_o,
    output logic [NUM_PARTS-1:0]     wrBlockMask_o,
    output logic                     busy_o,
    output logic                     reconfigAck_o,
    output logic                     reconfigErr_o
);
    localparam int PW = NUM_PARTS_LOG + 1;
    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DRAIN, SETTLE, ACK} state_t;

    state_t               state_q, state_d;
    logic [NUM_PARTS-1:0] gated_q, gated_d, mask_q, mask_d;
    logic [PW-1:0]        active_q, active_d, tgt_q, tgt_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 err_q, err_d;

    // Bits lo..hi-1 set; partitions are always the contiguous low-indexed set.
    function automatic logic [NUM_PARTS-1:0] span(input logic [PW-1:0] lo, input logic [PW-1:0] hi);
        logic [NUM_PARTS-1:0] m;
        m = '0;
        for (int p = 0; p < NUM_PARTS; p++) m[p] = (PW'(p) >= lo) && (PW'(p) < hi);
        return m;
    endfunction

    always_comb begin
        state_d  = state_q;
        gated_d  = gated_q;
        mask_d   = mask_q;
        active_d = active_q;
        tgt_d    = tgt_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        case (state_q)
            IDLE: if (reconfigReq_i) begin
                tgt_d = reqParts_i;
                err_d = 1'b0;
                if (reqParts_i == '0 || reqParts_i > PW'(NUM_PARTS)) begin
                    err_d   = 1'b1;
                    state_d = ACK;
                end else if (reqParts_i == active_q) begin
                    state_d = ACK;
                end else if (reqParts_i < active_q) begin
                    mask_d  = span(reqParts_i, active_q);
                    state_d = DRAIN;
                end else begin
                    gated_d = gated_q & ~span(active_q, reqParts_i);
                    cnt_d   = CW'(SETTLE_CYCLES);
                    state_d = SETTLE;
                end
            end
            // Only the partitions being removed need to be empty.
            DRAIN: if (&(partDrained_i | ~mask_q)) begin
                gated_d  = gated_q | mask_q;
                mask_d   = '0;
                active_d = tgt_q;
                state_d  = ACK;
            end
            SETTLE: if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end else if (ramReady_i) begin
                active_d = tgt_q;
                state_d  = ACK;
            end
            ACK: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            gated_q  <= '0;
            mask_q   <= '0;
            active_q <= PW'(NUM_PARTS);
            tgt_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gated_q  <= gated_d;
            mask_q   <= mask_d;
            active_q <= active_d;
            tgt_q    <= tgt_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign partitionGated_o = gated_q;
    assign activeParts_o    = active_q;
    assign wrBlockMask_o    = mask_q;
    assign busy_o           = state_q != IDLE;
    assign reconfigAck_o    = state_q == ACK;
    assign reconfigErr_o    = (state_q == ACK) && err_q;
endmodule

// File: tb/tb_ram_partition_gate_ctrl.sv
// tb_ram_partition_gate_ctrl: transaction-level checks of ram_partition_gate_ctrl
module tb_ram_partition_gate_ctrl;
    localparam int N = 8;
    localparam int S = 4;
    localparam int FULL = (1 << N) - 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         reconfigReq_i = 1'b0;
    logic [3:0]   reqParts_i = '0;
    logic [N-1:0] partDrained_i = '1;
    logic         ramReady_i = 1'b1;
    logic [N-1:0] partitionGated_o;
    logic [3:0]   activeParts_o;
    logic [N-1:0] wrBlockMask_o;
    logic         busy_o, reconfigAck_o, reconfigErr_o;

    int checks = 0;
    int failures = 0;
    int m_active = N;
    int m_gated = 0;

    ram_partition_gate_ctrl #(.NUM_PARTS(N), .NUM_PARTS_LOG(3), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .reconfigReq_i(reconfigReq_i), .reqParts_i(reqParts_i),
        .partDrained_i(partDrained_i), .ramReady_i(ramReady_i),
        .partitionGated_o(partitionGated_o), .activeParts_o(activeParts_o),
        .wrBlockMask_o(wrBlockMask_o), .busy_o(busy_o),
        .reconfigAck_o(reconfigAck_o), .reconfigErr_o(reconfigErr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gated"}, 32'(partitionGated_o), 0);
        chk({tag, "_active"}, 32'(activeParts_o), N);
        chk({tag, "_mask"}, 32'(wrBlockMask_o), 0);
        chk({tag, "_busy"}, 32'(busy_o), 0);
        chk({tag, "_ack"}, 32'(reconfigAck_o), 0);
        chk({tag, "_err"}, 32'(reconfigErr_o), 0);
    endtask

    // One request from the idle state. Cycle 0 is the cycle the request is sampled in.
    // drain_at: cycle from which every partition reports drained.
    // ready is low in cycles lo..lo+len-1. hold keeps the request high (with junk counts)
    // until the ack. rst3 asserts reset in the middle of cycle 3.
    task automatic run_req(input int tgt, input int drain_at, input int lo, input int len,
                           input bit hold, input bit rst3);
        int cur, ack_c, exp_mask, new_g, fin, low, c;
        bit err, up;
        cur = m_active;
        err = (tgt < 1) || (tgt > N);
        up = !err && tgt > cur;
        low = err ? 0 : (1 << tgt) - 1;
        if (err || tgt == cur) ack_c = 1;
        else if (tgt < cur) ack_c = (drain_at < 1 ? 1 : drain_at) + 1;
        else begin
            c = S + 1;
            while (c >= lo && c < lo + len) c++;
            ack_c = c + 1;
        end
        exp_mask = (!err && tgt < cur) ? (((1 << cur) - 1) & ~low) : 0;
        new_g = (err || tgt == cur) ? m_gated : (FULL & ~low);
        fin = (err || tgt == cur) ? cur : tgt;
        reqParts_i = 4'(tgt);
        reconfigReq_i = 1'b1;
        partDrained_i = (drain_at == 0 || tgt >= cur || err) ? N'(FULL) : N'(low);
        ramReady_i = 1'b1;
        for (int k = 1; k <= ack_c + 1; k++) begin
            @(negedge clk);
            chk($sformatf("busy_t%0d_c%0d", tgt, k), 32'(busy_o), 32'(k <= ack_c));
            chk($sformatf("ack_t%0d_c%0d", tgt, k), 32'(reconfigAck_o), 32'(k == ack_c));
            chk($sformatf("mask_t%0d_c%0d", tgt, k), 32'(wrBlockMask_o), k < ack_c ? exp_mask : 0);
            chk($sformatf("gated_t%0d_c%0d", tgt, k), 32'(partitionGated_o),
                k < ack_c ? (up ? new_g : m_gated) : new_g);
            chk($sformatf("active_t%0d_c%0d", tgt, k), 32'(activeParts_o), k < ack_c ? cur : fin);
            if (k == ack_c) chk($sformatf("err_t%0d", tgt), 32'(reconfigErr_o), 32'(err));
            if (rst3 && k == 3) begin
                #2 reset = 1'b1;
                #1 chk_reset_outputs("async_reset");
                reconfigReq_i = 1'b0;
                @(negedge clk);
                chk_reset_outputs("held_reset");
                reset = 1'b0;
                m_active = N;
                m_gated = 0;
                return;
            end
            reconfigReq_i = hold && k < ack_c;
            if (hold) reqParts_i = 4'($urandom_range(0, 9));
            partDrained_i = (k >= drain_at) ? N'(FULL) : N'(low);
            ramReady_i = !(k >= lo && k < lo + len);
        end
        m_active = fin;
        m_gated = new_g;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_reset_outputs("in_reset");
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk_reset_outputs("idle");
        run_req(3, 0, 1, 0, 0, 0);
        run_req(6, 0, 3, 6, 0, 0);
        run_req(4, 10, 1, 0, 0, 0);
        run_req(0, 0, 1, 0, 0, 0);
        run_req(9, 0, 1, 0, 1, 0);
        run_req(4, 0, 1, 0, 1, 0);
        run_req(7, 0, 2, 3, 1, 0);
        run_req(2, 3, 1, 0, 1, 0);
        run_req(8, 0, 1, 0, 0, 1);
        for (int i = 0; i < 40; i++)
            run_req($urandom_range(0, 9), $urandom_range(0, 6), $urandom_range(1, 8),
                    $urandom_range(0, 5), 1'($urandom_range(0, 1)), 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
